// File: rtl/gpr_wb_arbiter.sv
// Writeback arbiter for the single gpr write port: picks one of two requesters,
// registers the winning write, and tracks which registers have writes pending.
module gpr_wb_arbiter #(
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic [4:0]  req0_addr,
    input  logic [31:0] req0_data,
    output logic        req0_ready,

    input  logic        req1_valid,
    input  logic [4:0]  req1_addr,
    input  logic [31:0] req1_data,
    output logic        req1_ready,

    input  logic        claim_valid,
    input  logic [4:0]  claim_addr,

    output logic        gpr_we,
    output logic [4:0]  gpr_a3,
    output logic [31:0] gpr_wd,
    output logic [31:0] busy
);

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;
    localparam int unsigned CNT_W  = 8;

    localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] REG_ZERO   = '0;

    // Architectural state
    logic               gpr_we_q,     gpr_we_d;
    logic [ADDR_W-1:0]  gpr_a3_q,     gpr_a3_d;
    logic [DATA_W-1:0]  gpr_wd_q,     gpr_wd_d;
    logic [NREG-1:0]    busy_q,       busy_d;
    logic               rr_prefer1_q, rr_prefer1_d;
    logic [CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

    // Combinational grant and the selected payload
    logic               grant0_c;
    logic               grant1_c;
    logic               contention_c;
    logic               xfer_c;
    logic [ADDR_W-1:0]  sel_addr_c;
    logic [DATA_W-1:0]  sel_data_c;

    // Grant selection; nothing is granted while reset is held low
    always_comb begin
        grant0_c     = 1'b0;
        grant1_c     = 1'b0;
        contention_c = 1'b0;
        if (reset) begin
            if (req0_valid && req1_valid) begin
                contention_c = 1'b1;
                if (FIXED_PRIO) begin
                    grant1_c = (starve_cnt_q == STARVE_LIM);
                end else begin
                    grant1_c = rr_prefer1_q;
                end
                grant0_c = ~grant1_c;
            end else begin
                grant0_c = req0_valid;
                grant1_c = req1_valid;
            end
        end
    end

    assign req0_ready = grant0_c;
    assign req1_ready = grant1_c;

    // Payload mux for the winning requester
    always_comb begin
        xfer_c     = grant0_c | grant1_c;
        sel_addr_c = req0_addr;
        sel_data_c = req0_data;
        if (grant1_c) begin
            sel_addr_c = req1_addr;
            sel_data_c = req1_data;
        end
    end

    // Next-state: output register, arbitration state, scoreboard
    always_comb begin
        gpr_we_d     = 1'b0;
        gpr_a3_d     = gpr_a3_q;
        gpr_wd_d     = gpr_wd_q;
        rr_prefer1_d = rr_prefer1_q;
        starve_cnt_d = starve_cnt_q;
        busy_d       = busy_q;

        // A write to r0 is accepted but never reaches the register file
        if (xfer_c && (sel_addr_c != REG_ZERO)) begin
            gpr_we_d = 1'b1;
            gpr_a3_d = sel_addr_c;
            gpr_wd_d = sel_data_c;
        end

        if (grant0_c) begin
            rr_prefer1_d = 1'b1;
        end else if (grant1_c) begin
            rr_prefer1_d = 1'b0;
        end

        if (FIXED_PRIO) begin
            if (grant1_c) begin
                starve_cnt_d = '0;
            end else if (contention_c) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end

        // Clear on commit first so a same-edge claim of the same register wins
        if (gpr_we_q) begin
            busy_d[gpr_a3_q] = 1'b0;
        end
        if (claim_valid && (claim_addr != REG_ZERO)) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            gpr_we_q     <= 1'b0;
            gpr_a3_q     <= '0;
            gpr_wd_q     <= '0;
            busy_q       <= '0;
            rr_prefer1_q <= 1'b0;
            starve_cnt_q <= '0;
        end else begin
            gpr_we_q     <= gpr_we_d;
            gpr_a3_q     <= gpr_a3_d;
            gpr_wd_q     <= gpr_wd_d;
            busy_q       <= busy_d;
            rr_prefer1_q <= rr_prefer1_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign gpr_we = gpr_we_q;
    assign gpr_a3 = gpr_a3_q;
    assign gpr_wd = gpr_wd_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: a round-robin instance driven from a vector table,
// and a fixed-priority instance exercised with a starvation sequence.
module tb_gpr_wb_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        claim_valid;
    logic [4:0]  claim_addr;

    logic        rr_req0_ready, rr_req1_ready, rr_gpr_we;
    logic [4:0]  rr_gpr_a3;
    logic [31:0] rr_gpr_wd, rr_busy;
    logic        fp_req0_ready, fp_req1_ready, fp_gpr_we;
    logic [4:0]  fp_gpr_a3;
    logic [31:0] fp_gpr_wd, fp_busy;

    int checks = 0;
    int errors = 0;

    gpr_wb_arbiter #(.FIXED_PRIO(1'b0), .STARVE_MAX(8)) u_rr (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(rr_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(rr_req1_ready),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .gpr_we(rr_gpr_we), .gpr_a3(rr_gpr_a3), .gpr_wd(rr_gpr_wd), .busy(rr_busy)
    );

    gpr_wb_arbiter #(.FIXED_PRIO(1'b1), .STARVE_MAX(8)) u_fp (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(fp_req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(fp_req1_ready),
        .claim_valid(claim_valid), .claim_addr(claim_addr),
        .gpr_we(fp_gpr_we), .gpr_a3(fp_gpr_a3), .gpr_wd(fp_gpr_wd), .busy(fp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        r0v;
        logic [4:0]  r0a;
        logic [31:0] r0d;
        logic        r1v;
        logic [4:0]  r1a;
        logic [31:0] r1d;
        logic        cv;
        logic [4:0]  ca;
        logic        e0;
        logic        e1;
        logic        ewe;
        logic [4:0]  ea3;
        logic [31:0] ewd;
        logic [31:0] ebusy;
    } vec_t;

    localparam int NVEC = 30;
    vec_t tbl [NVEC];

    function automatic vec_t mk(
        input logic rst, input logic r0v, input logic [4:0] r0a, input logic [31:0] r0d,
        input logic r1v, input logic [4:0] r1a, input logic [31:0] r1d,
        input logic cv, input logic [4:0] ca,
        input logic e0, input logic e1, input logic ewe, input logic [4:0] ea3,
        input logic [31:0] ewd, input logic [31:0] ebusy);
        vec_t v;
        v.rst = rst; v.r0v = r0v; v.r0a = r0a; v.r0d = r0d;
        v.r1v = r1v; v.r1a = r1a; v.r1d = r1d; v.cv = cv; v.ca = ca;
        v.e0 = e0; v.e1 = e1; v.ewe = ewe; v.ea3 = ea3; v.ewd = ewd; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic rst, input logic r0v, input logic [4:0] r0a, input logic [31:0] r0d,
                         input logic r1v, input logic [4:0] r1a, input logic [31:0] r1d,
                         input logic cv, input logic [4:0] ca);
        reset = rst; req0_valid = r0v; req0_addr = r0a; req0_data = r0d;
        req1_valid = r1v; req1_addr = r1a; req1_data = r1d;
        claim_valid = cv; claim_addr = ca;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t, limit 100000", $time);
        $fatal(1);
    end

    initial begin
        // Inputs, then readys (current cycle), then registered outputs (prior edge)
        tbl[0]  = mk(0, 1, 8, 32'h11, 0, 0, 0, 0, 0,   0, 0, 0, 0, 32'h0, 32'h0);
        tbl[1]  = mk(0, 1, 8, 32'h11, 0, 0, 0, 0, 0,   0, 0, 0, 0, 32'h0, 32'h0);
        tbl[2]  = mk(0, 1, 8, 32'h11, 0, 0, 0, 0, 0,   0, 0, 0, 0, 32'h0, 32'h0);
        tbl[3]  = mk(1, 1, 8, 32'h11, 0, 0, 0, 0, 0,   1, 0, 0, 0, 32'h0, 32'h0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 1, 8, 32'h11, 32'h0);
        tbl[5]  = mk(1, 0, 0, 0, 1, 9, 32'hAAAAAAAA, 0, 0, 0, 1, 0, 8, 32'h11, 32'h0);
        tbl[6]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 1, 9, 32'hAAAAAAAA, 32'h0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 9, 32'hAAAAAAAA, 32'h0);
        tbl[8]  = mk(1, 1, 8, 32'h100, 1, 9, 32'h200, 0, 0, 1, 0, 0, 9, 32'hAAAAAAAA, 32'h0);
        tbl[9]  = mk(1, 1, 8, 32'h100, 1, 9, 32'h200, 0, 0, 0, 1, 1, 8, 32'h100, 32'h0);
        tbl[10] = mk(1, 1, 8, 32'h100, 1, 9, 32'h200, 0, 0, 1, 0, 1, 9, 32'h200, 32'h0);
        tbl[11] = mk(1, 1, 8, 32'h100, 1, 9, 32'h200, 0, 0, 0, 1, 1, 8, 32'h100, 32'h0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 1, 9, 32'h200, 32'h0);
        tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 1, 6,        0, 0, 0, 9, 32'h200, 32'h0);
        tbl[14] = mk(1, 1, 6, 32'h66, 0, 0, 0, 0, 0,   1, 0, 0, 9, 32'h200, 32'h40);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 1, 6, 32'h66, 32'h40);
        tbl[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 6, 32'h66, 32'h0);
        tbl[17] = mk(1, 0, 0, 0, 1, 6, 32'h77, 1, 6,   0, 1, 0, 6, 32'h66, 32'h0);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 1, 6,        0, 0, 1, 6, 32'h77, 32'h40);
        tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 6, 32'h77, 32'h40);
        tbl[20] = mk(1, 1, 6, 32'h88, 0, 0, 0, 0, 0,   1, 0, 0, 6, 32'h77, 32'h40);
        tbl[21] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0,        0, 0, 1, 6, 32'h88, 32'h40);
        tbl[22] = mk(1, 1, 0, 32'h12345678, 0, 0, 0, 1, 3, 1, 0, 0, 6, 32'h88, 32'h0);
        tbl[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 6, 32'h88, 32'h8);
        tbl[24] = mk(0, 1, 5, 32'h55, 0, 0, 0, 1, 7,   0, 0, 0, 6, 32'h88, 32'h8);
        tbl[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 32'h0, 32'h0);
        tbl[26] = mk(1, 1, 10, 32'hA0, 1, 11, 32'hB0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        tbl[27] = mk(1, 1, 12, 32'hC0, 1, 13, 32'hD0, 0, 0, 0, 1, 1, 10, 32'hA0, 32'h0);
        tbl[28] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 1, 13, 32'hD0, 32'h0);
        tbl[29] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 13, 32'hD0, 32'h0);

        drive(0, 1, 8, 32'h11, 0, 0, 0, 0, 0);
        @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i].rst, tbl[i].r0v, tbl[i].r0a, tbl[i].r0d,
                  tbl[i].r1v, tbl[i].r1a, tbl[i].r1d, tbl[i].cv, tbl[i].ca);
            #1;
            chk($sformatf("vec%0d req0_ready", i), 32'(rr_req0_ready), 32'(tbl[i].e0));
            chk($sformatf("vec%0d req1_ready", i), 32'(rr_req1_ready), 32'(tbl[i].e1));
            chk($sformatf("vec%0d gpr_we", i),     32'(rr_gpr_we),     32'(tbl[i].ewe));
            chk($sformatf("vec%0d gpr_a3", i),     32'(rr_gpr_a3),     32'(tbl[i].ea3));
            chk($sformatf("vec%0d gpr_wd", i),     rr_gpr_wd,          tbl[i].ewd);
            chk($sformatf("vec%0d busy", i),       rr_busy,            tbl[i].ebusy);
        end

        // Fixed priority: req1 force-granted after losing 8 contention cycles;
        // the loss count holds while req1 is idle (cycles 13-14)
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 20; c++) begin
            logic r1v;
            logic exp1;
            r1v  = !(c == 13 || c == 14);
            exp1 = (c == 9 || c == 20);
            @(negedge clk);
            drive(1, 1, 8, 32'h800 + 32'(c), r1v, 9, 32'h900 + 32'(c), 0, 0);
            #1;
            chk($sformatf("starve c%0d req0_ready", c), 32'(fp_req0_ready), 32'(!exp1));
            chk($sformatf("starve c%0d req1_ready", c), 32'(fp_req1_ready), 32'(exp1));
            if (c == 1) begin
                chk("starve reset gpr_we", 32'(fp_gpr_we), 32'h0);
                chk("starve reset gpr_a3", 32'(fp_gpr_a3), 32'h0);
                chk("starve reset busy",   fp_busy,        32'h0);
            end
            if (c == 10) begin
                chk("starve c10 gpr_we", 32'(fp_gpr_we), 32'h1);
                chk("starve c10 gpr_a3", 32'(fp_gpr_a3), 32'h9);
                chk("starve c10 gpr_wd", fp_gpr_wd,      32'h909);
            end
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("starve tail gpr_we", 32'(fp_gpr_we), 32'h1);
        chk("starve tail gpr_a3", 32'(fp_gpr_a3), 32'h9);
        chk("starve tail gpr_wd", fp_gpr_wd,      32'h914);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
